uart_tx_core: RTL and testbench

Serial UART transmitter, one stage downstream of the team's baud divider. Accepts a parallel word through a valid/ready handshake and shifts it out LSB-first on `tx` as a framed asynchronous character: start bit, data bits, optional parity bit, then stop bits. Every bit boundary is aligned to a single-cycle `baud_tick` strobe supplied by the divider stage. Sits between the application logic and the FPGA TX pin.

---
 rtl/uart_tx_core.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter core: accepts a parallel word over valid/ready and
// shifts it out LSB-first as start / data / optional parity / stop bits,
// with every line transition aligned to the divider's baud_tick strobe.
module uart_tx_core #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    // Reject unsupported frame formats while the design is being built.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_core: DATA_BITS must be 5..9");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_core: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic [IDX_W-1:0]     next_idx;
    logic                 parity_bit;

    assign next_idx   = bit_idx_q + IDX_W'(1);
    // Even parity is the XOR of the latched word; odd parity is its inverse.
    assign parity_bit = (PARITY == 2) ? ~(^data_q) : (^data_q);

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                // A tick coinciding with acceptance is deliberately ignored.
                if (tx_valid && ready_q) begin
                    data_d  = tx_data;
                    ready_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d      = data_q[0];
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY != 0) begin
                            tx_d    = parity_bit;
                            state_d = S_PAR;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = data_q[next_idx];
                    end
                end
            end
            S_PAR: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything, including baud_tick.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances (8N1, 8E1, 8O1, 8N2)
// share clock, reset, tick and data; each has its own tx_valid.
module tb_uart_tx_core;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic [3:0] tx_valid_v;
    logic [3:0] tx_w;
    logic [3:0] rdy_w;
    logic [3:0] done_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid_v[0]), .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0])
    );
    uart_tx_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid_v[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1])
    );
    uart_tx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid_v[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2])
    );
    uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid_v[3]), .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_done(done_w[3])
    );

    // Advance one clock and settle just past the edge.
    task automatic clk1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Handshake one word into instance sel with no tick on the accepting edge.
    task automatic accept(input int sel, input logic [7:0] word);
        tx_data         = word;
        tx_valid_v[sel] = 1'b1;
        baud_tick       = 1'b0;
        clk1();
        chk($sformatf("u%0d accept ready", sel), rdy_w[sel], 1'b0);
        chk($sformatf("u%0d accept tx", sel), tx_w[sel], 1'b1);
        tx_valid_v[sel] = 1'b0;
    endtask

    // n tick periods (3 idle clocks + tick); exp[i] is the line after tick i+1.
    // tx_data is scrambled every clock to show the latched word is used.
    task automatic run_bits(input int sel, input logic [15:0] exp, input int n);
        logic prev;
        prev = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3; g++) begin
                tx_data = 8'($urandom);
                clk1();
            end
            chk($sformatf("u%0d hold before tick%0d", sel, i + 1), tx_w[sel], prev);
            baud_tick = 1'b1;
            tx_data   = 8'($urandom);
            clk1();
            baud_tick = 1'b0;
            chk($sformatf("u%0d tx tick%0d", sel, i + 1), tx_w[sel], exp[i]);
            chk($sformatf("u%0d no done tick%0d", sel, i + 1), done_w[sel], 1'b0);
            prev = exp[i];
        end
    endtask

    // Tick that ends the final stop bit: done and ready rise together.
    task automatic finish_frame(input int sel);
        for (int g = 0; g < 3; g++) clk1();
        baud_tick = 1'b1;
        clk1();
        baud_tick = 1'b0;
        chk($sformatf("u%0d done pulse", sel), done_w[sel], 1'b1);
        chk($sformatf("u%0d ready at done", sel), rdy_w[sel], 1'b1);
        chk($sformatf("u%0d line idle at done", sel), tx_w[sel], 1'b1);
    endtask

    task automatic after_done_idle(input int sel);
        clk1();
        chk($sformatf("u%0d done one cycle", sel), done_w[sel], 1'b0);
        chk($sformatf("u%0d ready stays", sel), rdy_w[sel], 1'b1);
    endtask

    initial begin
        // Reset held with tick and valid asserted.
        rst        = 1'b1;
        baud_tick  = 1'b1;
        tx_valid_v = 4'b1111;
        tx_data    = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            clk1();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rst%0d u%0d tx", c, k), tx_w[k], 1'b1);
                chk($sformatf("rst%0d u%0d ready", c, k), rdy_w[k], 1'b0);
                chk($sformatf("rst%0d u%0d done", c, k), done_w[k], 1'b0);
            end
        end
        rst = 1'b0;
        clk1();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("release u%0d ready", k), rdy_w[k], 1'b1);
            chk($sformatf("release u%0d tx", k), tx_w[k], 1'b1);
        end
        tx_valid_v = '0;
        baud_tick  = 1'b0;
        clk1();

        // 8N1 0xA5.
        accept(0, 8'hA5);
        run_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        finish_frame(0);
        after_done_idle(0);

        // 8E1 / 8O1 parity: 0xA5 has four ones, 0x01 has one.
        accept(1, 8'hA5);
        run_bits(1, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        finish_frame(1);
        after_done_idle(1);
        accept(2, 8'hA5);
        run_bits(2, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        finish_frame(2);
        after_done_idle(2);
        accept(1, 8'h01);
        run_bits(1, {5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        finish_frame(1);
        after_done_idle(1);
        accept(2, 8'h01);
        run_bits(2, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
        finish_frame(2);
        after_done_idle(2);

        // 8N2 back-to-back with tx_valid held high.
        accept(3, 8'h00);
        tx_valid_v[3] = 1'b1;
        run_bits(3, {5'b0, 2'b11, 8'h00, 1'b0}, 11);
        tx_data = 8'hFF;
        finish_frame(3);
        tx_data = 8'hFF;
        clk1();
        chk("u3 b2b accepted ready", rdy_w[3], 1'b0);
        chk("u3 b2b done cleared", done_w[3], 1'b0);
        tx_valid_v[3] = 1'b0;
        run_bits(3, {5'b0, 2'b11, 8'hFF, 1'b0}, 11);
        finish_frame(3);
        after_done_idle(3);

        // Coincident tick on acceptance must not start the start bit early.
        tx_data       = 8'h3C;
        tx_valid_v[0] = 1'b1;
        baud_tick     = 1'b1;
        clk1();
        tx_valid_v[0] = 1'b0;
        baud_tick     = 1'b0;
        chk("u0 coincident tick line", tx_w[0], 1'b1);
        chk("u0 coincident tick ready", rdy_w[0], 1'b0);
        run_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        finish_frame(0);
        after_done_idle(0);

        // Reset during data bit 4 (0 for 0xA5), then a clean 0x55 frame.
        accept(0, 8'hA5);
        run_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 6);
        clk1();
        rst       = 1'b1;
        baud_tick = 1'b1;
        clk1();
        chk("u0 abort tx", tx_w[0], 1'b1);
        chk("u0 abort ready", rdy_w[0], 1'b0);
        chk("u0 abort done", done_w[0], 1'b0);
        rst       = 1'b0;
        baud_tick = 1'b0;
        clk1();
        chk("u0 after abort ready", rdy_w[0], 1'b1);
        for (int t = 0; t < 6; t++) begin
            baud_tick = 1'b1;
            clk1();
            baud_tick = 1'b0;
            clk1();
            chk($sformatf("u0 post-abort idle tx%0d", t), tx_w[0], 1'b1);
            chk($sformatf("u0 post-abort no done%0d", t), done_w[0], 1'b0);
        end
        accept(0, 8'h55);
        run_bits(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        finish_frame(0);
        after_done_idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
